// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and the block that drives or observes it.
// The master side also returns the combinational DUT response.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 1
);
  localparam int unsigned TT_W = N_OUT * (2 ** N_IN);

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic [TT_W-1:0]   exp_tt;
  logic [TT_W-1:0]   tt_bits;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_cnt;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail;

  modport master (
    output start, abort, exp_tt, dut_out,
    input  dut_in, tt_bits, busy, done, pass, err_cnt, fail_valid, first_fail
  );

  modport slave (
    input  start, abort, exp_tt, dut_out,
    output dut_in, tt_bits, busy, done, pass, err_cnt, fail_valid, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector, holds it SETTLE cycles,
// captures the response and scores it against an expected truth table.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.slave  bus
);
  localparam int unsigned TT_W  = N_OUT * (2 ** N_IN);
  localparam int unsigned IDX_W = $clog2(TT_W);
  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  base_c;
  logic              launch_c;
  logic              sample_c;
  logic              last_c;
  logic              mismatch_c;
  logic [ERR_W-1:0]  err_nxt_c;

  // Next state plus the per-edge launch/sample strobes; abort beats sampling.
  always_comb begin
    state_d    = state_q;
    launch_c   = 1'b0;
    sample_c   = 1'b0;
    last_c     = &bus.dut_in;
    base_c     = IDX_W'(bus.dut_in) * IDX_W'(N_OUT);
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          launch_c = 1'b1;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          sample_c = 1'b1;
          if (last_c) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    mismatch_c = sample_c && (bus.dut_out != bus.exp_tt[base_c +: N_OUT]);
    err_nxt_c  = bus.err_cnt + ERR_W'(mismatch_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Vector walk, capture and scoring; status flags follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      bus.dut_in     <= '0;
      bus.tt_bits    <= '0;
      bus.err_cnt    <= '0;
      bus.first_fail <= '0;
      bus.fail_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
    end else begin
      if (launch_c) begin
        cnt_q          <= '0;
        bus.dut_in     <= '0;
        bus.tt_bits    <= '0;
        bus.err_cnt    <= '0;
        bus.first_fail <= '0;
        bus.fail_valid <= 1'b0;
      end else if (state_q == APPLY && !bus.abort) begin
        if (sample_c) begin
          cnt_q                         <= '0;
          bus.tt_bits[base_c +: N_OUT]  <= bus.dut_out;
          bus.err_cnt                   <= err_nxt_c;
          if (mismatch_c && !bus.fail_valid) begin
            bus.first_fail <= bus.dut_in;
            bus.fail_valid <= 1'b1;
          end
          if (!last_c) bus.dut_in <= bus.dut_in + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      bus.busy <= (state_d == APPLY);
      bus.done <= (state_d == DONE);
      bus.pass <= (state_d == DONE) && (err_nxt_c == '0);
    end
  end
endmodule
